// File: rtl/op_decode.sv
// Instruction decoder: turns 9-bit fetch words into ALU micro-ops over a valid/ready pair.
// Define OP_DECODE_MACRO_EN to expand opcode 10 (NEG) into FLIP then ADD; otherwise 10 is illegal.
module op_decode (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] in_instr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_op,
  output logic [4:0] out_val,
  output logic [2:0] out_reg,
  output logic       out_last,
  output logic       illegal,
  output logic [7:0] illegal_cnt
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_FLIP  = 4'd4;
  localparam logic [3:0] OP_LAST  = 4'd8;
  localparam logic [4:0] VAL_ZERO = 5'd0;
  localparam logic [4:0] VAL_ONE  = 5'd1;
  localparam logic [7:0] CNT_MAX  = 8'd255;

`ifdef OP_DECODE_MACRO_EN
  localparam logic [3:0] OP_NEG   = 4'd10;
  typedef enum logic [0:0] {RUN = 1'b0, EXPAND = 1'b1} state_t;
`else
  typedef enum logic [0:0] {RUN = 1'b0} state_t;
`endif

  state_t     state_q, state_d;
  logic       out_valid_q, out_valid_d;
  logic [3:0] op_q, op_d;
  logic [4:0] val_q, val_d;
  logic [2:0] reg_q, reg_d;
  logic       last_q, last_d;
  logic       illegal_q, illegal_d;
  logic [7:0] cnt_q, cnt_d;
`ifdef OP_DECODE_MACRO_EN
  logic [2:0] pend_reg_q, pend_reg_d;
`endif

  logic [3:0] in_opcode_s;
  logic [2:0] in_reg_s;
  logic [1:0] in_vsel_s;
  logic       in_ready_s;
  logic       accept_s;
  logic       handshake_s;
  logic       op_legal_s;

  assign in_opcode_s = in_instr[8:5];
  assign in_reg_s    = in_instr[4:2];
  assign in_vsel_s   = in_instr[1:0];
  assign op_legal_s  = (in_opcode_s <= OP_LAST);

  // Ready only in RUN and when the output slot is empty or draining this cycle.
  assign in_ready_s  = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept_s    = in_valid && in_ready_s;
  assign handshake_s = out_valid_q && out_ready;

  // Next-state and micro-op load logic.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    op_d        = op_q;
    val_d       = val_q;
    reg_d       = reg_q;
    last_d      = last_q;
    illegal_d   = 1'b0;
    cnt_d       = cnt_q;
`ifdef OP_DECODE_MACRO_EN
    pend_reg_d  = pend_reg_q;
`endif

    if (handshake_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      RUN: begin
        if (accept_s) begin
          if (op_legal_s) begin
            out_valid_d = 1'b1;
            op_d        = in_opcode_s;
            val_d       = {3'b000, in_vsel_s};
            reg_d       = in_reg_s;
            last_d      = 1'b1;
`ifdef OP_DECODE_MACRO_EN
          end else if (in_opcode_s == OP_NEG) begin
            // NEG x = ~x + 1: emit FLIP now, hold the register for the trailing ADD.
            out_valid_d = 1'b1;
            op_d        = OP_FLIP;
            val_d       = VAL_ZERO;
            reg_d       = in_reg_s;
            last_d      = 1'b0;
            pend_reg_d  = in_reg_s;
            state_d     = EXPAND;
`endif
          end else begin
            illegal_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + 8'd1;
            end else begin
              cnt_d = cnt_q;
            end
          end
        end else begin
          state_d = RUN;
        end
      end
`ifdef OP_DECODE_MACRO_EN
      EXPAND: begin
        if (handshake_s) begin
          out_valid_d = 1'b1;
          op_d        = OP_ADD;
          val_d       = VAL_ONE;
          reg_d       = pend_reg_q;
          last_d      = 1'b1;
          state_d     = RUN;
        end else begin
          state_d = EXPAND;
        end
      end
`endif
      default: begin
        state_d     = RUN;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      op_q        <= 4'd0;
      val_q       <= 5'd0;
      reg_q       <= 3'd0;
      last_q      <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= 8'd0;
`ifdef OP_DECODE_MACRO_EN
      pend_reg_q  <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      val_q       <= val_d;
      reg_q       <= reg_d;
      last_q      <= last_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
`ifdef OP_DECODE_MACRO_EN
      pend_reg_q  <= pend_reg_d;
`endif
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_q;
  assign out_op      = op_q;
  assign out_val     = val_q;
  assign out_reg     = reg_q;
  assign out_last    = last_q;
  assign illegal     = illegal_q;
  assign illegal_cnt = cnt_q;

endmodule
